// File: rtl/set_req_arbiter_pkg.sv
// ============================================================================
// Module      : set_req_arbiter_pkg
// Description : Shared field widths, mode and FSM encodings for the SET
//               request arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package set_req_arbiter_pkg;

  localparam int c_central_w = 24;
  localparam int c_radius_w  = 12;
  localparam int c_mode_w    = 2;
  localparam int c_cand_w    = 8;
  localparam int c_cnt_w     = 16;

  typedef enum logic [1:0] {
    MODE_0 = 2'b00,
    MODE_1 = 2'b01,
    MODE_2 = 2'b10,
    MODE_3 = 2'b11
  } set_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_RESP  = 2'b11
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/set_req_arbiter_rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick: first asserted request at or
//               after pointer p, wrapping NREQ-1 -> 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
  import set_req_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDXW = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] p,
  output logic [NREQ-1:0] grant,
  output logic [IDXW-1:0] idx
);

  int   w_j;
  logic w_found;

  always_comb begin
    grant   = '0;
    idx     = '0;
    w_found = 1'b0;
    w_j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_j = int'(p) + k;
      if (w_j >= NREQ) w_j = w_j - NREQ;
      if (!w_found && req[w_j]) begin
        w_found    = 1'b1;
        grant[w_j] = 1'b1;
        idx        = IDXW'(w_j);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/set_req_arbiter.sv
// ============================================================================
// Module      : set_req_arbiter
// Description : Shares one SET core between NREQ requesters; round-robin
//               issue, wait for result or timeout, respond to the winner.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module set_req_arbiter
  import set_req_arbiter_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NREQ-1:0]             req,
  input  logic [c_central_w*NREQ-1:0] req_central,
  input  logic [c_radius_w*NREQ-1:0]  req_radius,
  input  logic [c_mode_w*NREQ-1:0]    req_mode,
  output logic [NREQ-1:0]             req_ack,
  output logic [NREQ-1:0]             rsp_valid,
  output logic [c_cand_w-1:0]         rsp_candidate,
  output logic                        rsp_err,
  output logic                        arb_busy,
  output logic                        set_en,
  output logic [c_central_w-1:0]      set_central,
  output logic [c_radius_w-1:0]       set_radius,
  output logic [c_mode_w-1:0]         set_mode,
  input  logic                        set_busy,
  input  logic                        set_valid,
  input  logic [c_cand_w-1:0]         set_candidate
);

  localparam int IDXW = $clog2(NREQ);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);
  localparam logic [IDXW-1:0]    c_idx_last = IDXW'(NREQ - 1);

  arb_state_t              r_state, w_state_nxt;
  logic [IDXW-1:0]         r_ptr, w_ptr_nxt;
  logic [c_cnt_w-1:0]      r_cnt, w_cnt_nxt;
  logic [NREQ-1:0]         r_win, w_win_nxt;
  logic [NREQ-1:0]         r_req_ack, w_req_ack_nxt;
  logic [NREQ-1:0]         r_rsp_valid, w_rsp_valid_nxt;
  logic [c_cand_w-1:0]     r_rsp_cand, w_rsp_cand_nxt;
  logic                    r_rsp_err, w_rsp_err_nxt;
  logic                    r_set_en, w_set_en_nxt;
  logic [c_central_w-1:0]  r_set_central, w_set_central_nxt;
  logic [c_radius_w-1:0]   r_set_radius, w_set_radius_nxt;
  logic [c_mode_w-1:0]     r_set_mode, w_set_mode_nxt;

  logic [NREQ-1:0]         w_grant;
  logic [IDXW-1:0]         w_idx;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_rr (
    .req   (req),
    .p     (r_ptr),
    .grant (w_grant),
    .idx   (w_idx)
  );

  always_comb begin
    w_state_nxt       = r_state;
    w_ptr_nxt         = r_ptr;
    w_cnt_nxt         = r_cnt;
    w_win_nxt         = r_win;
    w_req_ack_nxt     = '0;
    w_rsp_valid_nxt   = '0;
    w_rsp_cand_nxt    = r_rsp_cand;
    w_rsp_err_nxt     = r_rsp_err;
    w_set_en_nxt      = 1'b0;
    w_set_central_nxt = '0;
    w_set_radius_nxt  = '0;
    w_set_mode_nxt    = '0;
    case (r_state)
      ST_IDLE: begin
        // Payload goes straight into the set_* registers so it is on the
        // core interface for the single ISSUE cycle.
        if ((|req) && !set_busy) begin
          w_state_nxt       = ST_ISSUE;
          w_win_nxt         = w_grant;
          w_req_ack_nxt     = w_grant;
          w_set_en_nxt      = 1'b1;
          w_set_central_nxt = req_central[int'(w_idx)*c_central_w +: c_central_w];
          w_set_radius_nxt  = req_radius[int'(w_idx)*c_radius_w +: c_radius_w];
          w_set_mode_nxt    = req_mode[int'(w_idx)*c_mode_w +: c_mode_w];
          w_ptr_nxt         = (w_idx == c_idx_last) ? '0 : w_idx + 1'b1;
        end
      end
      ST_ISSUE: begin
        w_state_nxt = ST_WAIT;
        w_cnt_nxt   = '0;
      end
      ST_WAIT: begin
        // A result arriving on the last counted cycle still beats the timeout.
        if (set_valid) begin
          w_state_nxt     = ST_RESP;
          w_rsp_valid_nxt = r_win;
          w_rsp_cand_nxt  = set_candidate;
          w_rsp_err_nxt   = 1'b0;
        end else if (r_cnt == c_cnt_last) begin
          w_state_nxt     = ST_RESP;
          w_rsp_valid_nxt = r_win;
          w_rsp_cand_nxt  = '0;
          w_rsp_err_nxt   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_RESP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_ptr         <= '0;
      r_cnt         <= '0;
      r_win         <= '0;
      r_req_ack     <= '0;
      r_rsp_valid   <= '0;
      r_rsp_cand    <= '0;
      r_rsp_err     <= 1'b0;
      r_set_en      <= 1'b0;
      r_set_central <= '0;
      r_set_radius  <= '0;
      r_set_mode    <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_ptr         <= w_ptr_nxt;
      r_cnt         <= w_cnt_nxt;
      r_win         <= w_win_nxt;
      r_req_ack     <= w_req_ack_nxt;
      r_rsp_valid   <= w_rsp_valid_nxt;
      r_rsp_cand    <= w_rsp_cand_nxt;
      r_rsp_err     <= w_rsp_err_nxt;
      r_set_en      <= w_set_en_nxt;
      r_set_central <= w_set_central_nxt;
      r_set_radius  <= w_set_radius_nxt;
      r_set_mode    <= w_set_mode_nxt;
    end
  end

  assign req_ack       = r_req_ack;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_candidate = r_rsp_cand;
  assign rsp_err       = r_rsp_err;
  assign arb_busy      = (r_state != ST_IDLE);
  assign set_en        = r_set_en;
  assign set_central   = r_set_central;
  assign set_radius    = r_set_radius;
  assign set_mode      = r_set_mode;

endmodule

`default_nettype wire

// File: tb/tb_set_req_arbiter.sv
// ============================================================================
// Module      : tb_set_req_arbiter
// Description : Directed self-checking bench for set_req_arbiter with a
//               behavioural SET responder of programmable latency.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_set_req_arbiter;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [95:0] req_central;
  logic [47:0] req_radius;
  logic [7:0]  req_mode;
  logic [3:0]  req_ack;
  logic [3:0]  rsp_valid;
  logic [7:0]  rsp_candidate;
  logic        rsp_err;
  logic        arb_busy;
  logic        set_en;
  logic [23:0] set_central;
  logic [11:0] set_radius;
  logic [1:0]  set_mode;
  logic        set_busy;
  logic        set_valid;
  logic [7:0]  set_candidate;

  set_req_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .req_central   (req_central),
    .req_radius    (req_radius),
    .req_mode      (req_mode),
    .req_ack       (req_ack),
    .rsp_valid     (rsp_valid),
    .rsp_candidate (rsp_candidate),
    .rsp_err       (rsp_err),
    .arb_busy      (arb_busy),
    .set_en        (set_en),
    .set_central   (set_central),
    .set_radius    (set_radius),
    .set_mode      (set_mode),
    .set_busy      (set_busy),
    .set_valid     (set_valid),
    .set_candidate (set_candidate)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  bit         stub_on;
  int         stub_lat;
  int         stub_cnt;
  bit         stub_pending;
  logic [7:0] stub_res;
  bit         auto_drop;

  int          ack_log[$];
  int          rsp_log[$];
  logic [7:0]  cand_log[$];
  logic        err_log[$];
  int          rsp_step;
  int          en_step;
  int          en_count;
  int          zero_viol;
  int          onehot_viol;
  logic [23:0] en_c;
  logic [11:0] en_r;
  logic [1:0]  en_m;

  function automatic int first_one(logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Behavioural SET core results for the known command vectors.
  function automatic logic [7:0] set_model(logic [23:0] c, logic [11:0] r, logic [1:0] m);
    if (c == 24'h550000 && r == 12'h300 && m == 2'b00) return 8'd29;
    if (c == 24'h553300 && r == 12'h330 && m == 2'b01) return 8'd13;
    if (c == 24'h553300 && r == 12'h330 && m == 2'b10) return 8'd30;
    if (c == 24'h553362 && r == 12'h332 && m == 2'b11) return 8'd14;
    return 8'd7;
  endfunction

  task automatic set_port(int i, logic [23:0] c, logic [11:0] r, logic [1:0] m);
    req_central[i*24 +: 24] = c;
    req_radius[i*12 +: 12]  = r;
    req_mode[i*2 +: 2]      = m;
  endtask

  task automatic clear_logs();
    ack_log.delete();
    rsp_log.delete();
    cand_log.delete();
    err_log.delete();
    rsp_step = -1;
    en_step  = -1;
    en_count = 0;
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if (set_valid) set_valid = 1'b0;
    if (stub_pending) begin
      stub_cnt--;
      if (stub_cnt == 0) begin
        set_valid     = 1'b1;
        set_candidate = stub_res;
        stub_pending  = 1'b0;
      end
    end
    if (set_en && stub_on) begin
      stub_pending = 1'b1;
      stub_cnt     = stub_lat;
      stub_res     = set_model(set_central, set_radius, set_mode);
    end
    if (set_en) begin
      en_count++;
      en_step = cyc;
      en_c    = set_central;
      en_r    = set_radius;
      en_m    = set_mode;
    end else if ({set_central, set_radius, set_mode} != '0) begin
      zero_viol++;
    end
    if (req_ack != '0) begin
      if ($countones(req_ack) != 1) onehot_viol++;
      ack_log.push_back(first_one(req_ack));
      if (auto_drop) req = req & ~req_ack;
    end
    if (rsp_valid != '0) begin
      if ($countones(rsp_valid) != 1) onehot_viol++;
      rsp_log.push_back(first_one(rsp_valid));
      cand_log.push_back(rsp_candidate);
      err_log.push_back(rsp_err);
      rsp_step = cyc;
    end
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    req           = '0;
    req_central   = '0;
    req_radius    = '0;
    req_mode      = '0;
    set_busy      = 1'b0;
    set_valid     = 1'b0;
    set_candidate = '0;
    stub_pending  = 1'b0;
    stub_on       = 1'b1;
    stub_lat      = 3;
    auto_drop     = 1'b1;
    step();
    step();
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({req_ack, rsp_valid, arb_busy, set_en} !== '0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got ack=%b rsp=%b busy=%b en=%b required all 0", req_ack, rsp_valid, arb_busy, set_en);
    end
    n_cmp++;
    if ({rsp_candidate, rsp_err, set_central, set_radius, set_mode} !== '0) begin
      n_bad++;
      $display("FAIL reset_data: got cand=%0d err=%b c=%h r=%h m=%b required all 0", rsp_candidate, rsp_err, set_central, set_radius, set_mode);
    end
    // Async reset while issuing a command.
    stub_on = 1'b0;
    set_port(0, 24'h550000, 12'h300, 2'b00);
    req = 4'b0001;
    step();
    n_cmp++;
    if (set_en !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_pre_issue: set_en got %b required 1", set_en);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({req_ack, set_en, arb_busy, set_central, set_radius, set_mode} !== '0) begin
      n_bad++;
      $display("FAIL reset_async_issue: got ack=%b en=%b busy=%b c=%h required all 0", req_ack, set_en, arb_busy, set_central);
    end
    step();
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    set_port(0, 24'h550000, 12'h300, 2'b00);
    req = 4'b0001;
    step();
    n_cmp++;
    if (req_ack !== 4'b0001 || set_en !== 1'b1) begin
      n_bad++;
      $display("FAIL single_first_cycle: got ack=%b en=%b required 0001/1", req_ack, set_en);
    end
    for (int i = 0; i < 40 && rsp_log.size() < 1; i++) step();
    step(); step(); step();
    n_cmp++;
    if (ack_log.size() != 1 || en_count != 1) begin
      n_bad++;
      $display("FAIL single_pulses: got acks=%0d set_en_cycles=%0d required 1/1", ack_log.size(), en_count);
    end
    n_cmp++;
    if ({en_c, en_r, en_m} !== {24'h550000, 12'h300, 2'b00}) begin
      n_bad++;
      $display("FAIL single_payload: got %h/%h/%b required 550000/300/00", en_c, en_r, en_m);
    end
    n_cmp++;
    if (rsp_log.size() != 1) begin
      n_bad++;
      $display("FAIL single_rsp_count: got %0d required 1", rsp_log.size());
    end else begin
      n_cmp++;
      if (rsp_log[0] != 0 || cand_log[0] !== 8'd29 || err_log[0] !== 1'b0) begin
        n_bad++;
        $display("FAIL single_rsp: got port=%0d cand=%0d err=%b required 0/29/0", rsp_log[0], cand_log[0], err_log[0]);
      end
    end
    n_cmp++;
    if (arb_busy !== 1'b0 || rsp_candidate !== 8'd29 || rsp_valid !== 4'b0000) begin
      n_bad++;
      $display("FAIL single_after: got busy=%b cand=%0d rsp=%b required 0/29/0000", arb_busy, rsp_candidate, rsp_valid);
    end
  endtask

  task automatic test_all_four();
    int exp_c[4] = '{29, 13, 30, 14};
    do_reset();
    set_port(0, 24'h550000, 12'h300, 2'b00);
    set_port(1, 24'h553300, 12'h330, 2'b01);
    set_port(2, 24'h553300, 12'h330, 2'b10);
    set_port(3, 24'h553362, 12'h332, 2'b11);
    req = 4'b1111;
    for (int i = 0; i < 120 && rsp_log.size() < 4; i++) step();
    n_cmp++;
    if (rsp_log.size() != 4) begin
      n_bad++;
      $display("FAIL all4_count: got %0d responses required 4", rsp_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (rsp_log[i] != i || ack_log[i] != i || cand_log[i] !== exp_c[i][7:0] || err_log[i] !== 1'b0) begin
          n_bad++;
          $display("FAIL all4_rsp%0d: got port=%0d ack=%0d cand=%0d err=%b required %0d/%0d/%0d/0",
                   i, rsp_log[i], ack_log[i], cand_log[i], err_log[i], i, i, exp_c[i]);
        end
      end
    end
  endtask

  task automatic test_fairness();
    do_reset();
    auto_drop = 1'b0;
    req = 4'b0101;
    for (int i = 0; i < 120 && ack_log.size() < 4; i++) step();
    n_cmp++;
    if (ack_log.size() < 4) begin
      n_bad++;
      $display("FAIL fair_count: got %0d grants required 4", ack_log.size());
    end else begin
      n_cmp++;
      if (ack_log[0] != 0 || ack_log[1] != 2 || ack_log[2] != 0 || ack_log[3] != 2) begin
        n_bad++;
        $display("FAIL fair_order: got %0d,%0d,%0d,%0d required 0,2,0,2", ack_log[0], ack_log[1], ack_log[2], ack_log[3]);
      end
    end
    req = '0;
  endtask

  task automatic test_timeout();
    do_reset();
    stub_on = 1'b0;
    set_port(1, 24'h123456, 12'h789, 2'b01);
    req = 4'b0010;
    for (int i = 0; i < 40 && rsp_log.size() < 1; i++) step();
    n_cmp++;
    if (rsp_log.size() != 1) begin
      n_bad++;
      $display("FAIL timeout_count: got %0d responses required 1", rsp_log.size());
    end else begin
      n_cmp++;
      if (rsp_log[0] != 1 || cand_log[0] !== 8'd0 || err_log[0] !== 1'b1 || (rsp_step - en_step) != TIMEOUT + 1) begin
        n_bad++;
        $display("FAIL timeout_rsp: got port=%0d cand=%0d err=%b delay=%0d required 1/0/1/%0d",
                 rsp_log[0], cand_log[0], err_log[0], rsp_step - en_step, TIMEOUT + 1);
      end
    end
    step(); step();
    // Stray set_valid while idle must not produce a response.
    set_valid = 1'b1;
    set_candidate = 8'h55;
    step(); step(); step();
    n_cmp++;
    if (rsp_log.size() != 1 || rsp_err !== 1'b1 || rsp_candidate !== 8'd0 || arb_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_hold: got rsps=%0d err=%b cand=%0d busy=%b required 1/1/0/0", rsp_log.size(), rsp_err, rsp_candidate, arb_busy);
    end
    // Result on the final counted cycle wins over the timeout.
    clear_logs();
    stub_on  = 1'b1;
    stub_lat = TIMEOUT;
    set_port(3, 24'h553362, 12'h332, 2'b11);
    req = 4'b1000;
    for (int i = 0; i < 40 && rsp_log.size() < 1; i++) step();
    n_cmp++;
    if (rsp_log.size() != 1) begin
      n_bad++;
      $display("FAIL tie_count: got %0d responses required 1", rsp_log.size());
    end else begin
      n_cmp++;
      if (rsp_log[0] != 3 || cand_log[0] !== 8'd14 || err_log[0] !== 1'b0 || (rsp_step - en_step) != TIMEOUT + 1) begin
        n_bad++;
        $display("FAIL tie_rsp: got port=%0d cand=%0d err=%b delay=%0d required 3/14/0/%0d",
                 rsp_log[0], cand_log[0], err_log[0], rsp_step - en_step, TIMEOUT + 1);
      end
    end
    // One cycle too late: timeout, and the late result lands in RESP.
    step(); step();
    clear_logs();
    stub_lat = TIMEOUT + 1;
    set_port(0, 24'h550000, 12'h300, 2'b00);
    req = 4'b0001;
    for (int i = 0; i < 40; i++) step();
    n_cmp++;
    if (rsp_log.size() != 1) begin
      n_bad++;
      $display("FAIL late_count: got %0d responses required 1", rsp_log.size());
    end else begin
      n_cmp++;
      if (rsp_log[0] != 0 || cand_log[0] !== 8'd0 || err_log[0] !== 1'b1) begin
        n_bad++;
        $display("FAIL late_rsp: got port=%0d cand=%0d err=%b required 0/0/1", rsp_log[0], cand_log[0], err_log[0]);
      end
    end
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    stub_on = 1'b0;
    req = 4'b0100;
    for (int i = 0; i < 40 && rsp_log.size() < 1; i++) step();
    clear_logs();
    req = 4'b0010;
    for (int i = 0; i < 10 && en_count < 1; i++) step();
    step(); step(); step();
    n_cmp++;
    if (arb_busy !== 1'b1 || rsp_err !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_pre: got busy=%b err=%b required 1/1", arb_busy, rsp_err);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({arb_busy, rsp_err, rsp_candidate, rsp_valid, req_ack, set_en} !== '0) begin
      n_bad++;
      $display("FAIL abort_async: got busy=%b err=%b cand=%0d rsp=%b required all 0", arb_busy, rsp_err, rsp_candidate, rsp_valid);
    end
    step(); step();
    rst = 1'b0;
    clear_logs();
    stub_on  = 1'b1;
    stub_lat = 2;
    req = 4'b0101;
    for (int i = 0; i < 40 && rsp_log.size() < 1; i++) step();
    n_cmp++;
    if (ack_log.size() < 1 || rsp_log.size() != 1) begin
      n_bad++;
      $display("FAIL abort_next_count: got acks=%0d rsps=%0d required >=1/1", ack_log.size(), rsp_log.size());
    end else begin
      n_cmp++;
      if (ack_log[0] != 0 || rsp_log[0] != 0) begin
        n_bad++;
        $display("FAIL abort_next: got ack=%0d rsp=%0d required 0/0", ack_log[0], rsp_log[0]);
      end
    end
    set_busy = 1'b1;
    clear_logs();
    for (int i = 0; i < 10; i++) step();
    n_cmp++;
    if (en_count != 0 || ack_log.size() != 0) begin
      n_bad++;
      $display("FAIL busy_block: got set_en=%0d acks=%0d required 0/0", en_count, ack_log.size());
    end
    set_busy = 1'b0;
    step();
    n_cmp++;
    if (req_ack !== 4'b0100) begin
      n_bad++;
      $display("FAIL busy_release: got ack=%b required 0100", req_ack);
    end
  endtask

  initial begin
    zero_viol   = 0;
    onehot_viol = 0;
    test_reset();
    test_single();
    test_all_four();
    test_fairness();
    test_timeout();
    test_reset_in_wait();
    n_cmp++;
    if (zero_viol != 0 || onehot_viol != 0) begin
      n_bad++;
      $display("FAIL protocol: got payload_when_idle=%0d non_onehot=%0d required 0/0", zero_viol, onehot_viol);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/set_req_arbiter.md
SET_REQ_ARBITER -- requirements
Module: set_req_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing one SET core; legal range 2..8.
REQ-002 Parameter TIMEOUT, default 1024: max cycles in WAIT before an error response; legal range 2..65535.
REQ-003 clk  input  1  sole clock; all state updates on posedge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req  input  NREQ  per-requester request; held high with stable payload until req_ack.
REQ-006 req_central  input  24*NREQ  packed central word; slice i = bits [24i+23:24i].
REQ-007 req_radius  input  12*NREQ  packed radius word; slice i = bits [12i+11:12i].
REQ-008 req_mode  input  2*NREQ  packed mode; slice i = bits [2i+1:2i].
REQ-009 req_ack  output  NREQ  one-cycle pulse, one-hot: request i accepted.
REQ-010 rsp_valid  output  NREQ  one-cycle pulse, one-hot: result for requester i.
REQ-011 rsp_candidate  output  8  candidate count, qualified by rsp_valid.
REQ-012 rsp_err  output  1  timeout flag, qualified by rsp_valid.
REQ-013 arb_busy  output  1  high in every state except IDLE.
REQ-014 set_en, set_central[23:0], set_radius[11:0], set_mode[1:0]  outputs  command to SET core.
REQ-015 set_busy, set_valid, set_candidate[7:0]  inputs  status and result from SET core.

Function
REQ-016 FSM states: IDLE, ISSUE, WAIT, RESP; all outputs registered.
REQ-017 IDLE -> ISSUE at a posedge where |req==1 and set_busy==0; winner index and winner payload latched on that edge.
REQ-018 IDLE with set_busy==1 or req==0: stay; no ack, no set_en.
REQ-019 ISSUE lasts exactly one cycle: set_en=1, set_* = latched payload, req_ack[winner]=1; next state WAIT.
REQ-020 set_central/radius/mode = 0 whenever set_en=0.
REQ-021 WAIT: cycle counter starts at 0 on entry, increments each cycle; set_valid==1 -> latch set_candidate, go RESP with err=0.
REQ-022 WAIT: counter reaching TIMEOUT-1 with no set_valid -> go RESP with err=1, candidate=0.
REQ-023 set_valid and timeout in same cycle: valid wins (err=0).
REQ-024 set_valid in IDLE, ISSUE or RESP: ignored, no response generated.
REQ-025 RESP lasts one cycle: rsp_valid[winner]=1, rsp_candidate/rsp_err driven; next state IDLE; rsp_candidate/rsp_err hold value until next RESP.
REQ-026 Arbitration: round-robin; search starts at pointer p, ascending index with wrap NREQ-1 -> 0; first asserted req wins.
REQ-027 Pointer update on ISSUE entry: p = (winner+1) mod NREQ.
REQ-028 Request dropped before acceptance: never latched, no ack, no response.
REQ-029 Minimum throughput: one command per 4 cycles (IDLE, ISSUE, WAIT>=1, RESP) plus SET latency.

Reset
REQ-030 rst high: state=IDLE, p=0, counter=0, all outputs 0 (req_ack, rsp_valid, rsp_candidate, rsp_err, arb_busy, set_en, set_central, set_radius, set_mode), immediately and independent of clk.
REQ-031 Reset mid-operation (any state): in-flight command discarded, no rsp_valid issued for it.

Structure
REQ-032 Shared header set_pkg.vh holds: field widths (24/12/2/8), mode encodings 2'b00..2'b11, FSM state encodings.
REQ-033 Round-robin selection is one sub-module rr_arbiter (inputs req, p; outputs one-hot grant and index); FSM, counter and payload registers stay in set_req_arbiter.

Verification
REQ-034 Bench instantiates set_req_arbiter (NREQ=4) with the real SET core; checks each requester against expected results.
REQ-035 Single req[0], central 24'h550000, radius 12'h300, mode 2'b00 -> req_ack[0] one cycle, set_en one cycle with same payload, rsp_valid[0] with candidate 29, err 0.
REQ-036 All four req at once: {550000,300,00}, {553300,330,01}, {553300,330,10}, {553362,332,11} on ports 0..3 -> service order 0,1,2,3; candidates 29,13,30,14.
REQ-037 Ports 0 and 2 requesting continuously from reset -> grant order 0,2,0,2; port 2 never waits more than one other grant.
REQ-038 Stub SET never raising set_valid, TIMEOUT=16 -> rsp_valid with rsp_err=1, candidate 0, 16 cycles after WAIT entry; then IDLE, next request serviced normally.
REQ-039 rst asserted during WAIT -> all outputs 0 asynchronously, no rsp_valid for the aborted command, next grant goes to port 0; set_busy forced high -> no set_en, no req_ack.
